// File: rtl/ysyx_22050598_csr_file.sv
// M-mode CSR file and trap sequencer with a valid/ready request and a registered one-cycle response.
// Optional mcycle counter at 0xB00 is enabled by defining YSYX_22050598_CSR_MCYCLE_EN.
module ysyx_22050598_csr_file #(
    parameter int              XLEN             = 64,
    parameter logic [XLEN-1:0] MSTATUS_RESETVAL = XLEN'('h1800),
    parameter logic [XLEN-1:0] MTVEC_RESETVAL   = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      op_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_src_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            timer_irq_i,
    output logic            rsp_valid_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            illegal_o,
    output logic            irq_taken_o
);

    typedef enum logic {IDLE, RESP} state_t;

    localparam logic [2:0] OP_RW    = 3'b001;
    localparam logic [2:0] OP_RS    = 3'b010;
    localparam logic [2:0] OP_RC    = 3'b011;
    localparam logic [2:0] OP_ECALL = 3'b100;
    localparam logic [2:0] OP_MRET  = 3'b101;

    state_t          state;
    logic [XLEN-1:0] mstatus, mie, mtvec, mepc, mcause, mip;
    logic [XLEN-1:0] rd_val, wval, mstatus_trap, mstatus_mret;
    logic            rd_ok, is_csr, accept, irq, ecall, mret, wr_en;
`ifdef YSYX_22050598_CSR_MCYCLE_EN
    logic [XLEN-1:0] mcycle;
`endif

    assign req_ready_o = (state == IDLE);
    assign accept      = req_valid_i && (state == IDLE);
    assign irq         = accept && timer_irq_i && mstatus[3] && mie[7];
    assign ecall       = accept && !irq && (op_i == OP_ECALL);
    assign mret        = accept && !irq && (op_i == OP_MRET);
    assign is_csr      = (op_i == OP_RW) || (op_i == OP_RS) || (op_i == OP_RC);
    assign mip         = XLEN'({timer_irq_i, 7'b0});

    // Trap entry: MPIE<=MIE, MIE<=0, MPP<=M. Return: MIE<=MPIE, MPIE<=1, MPP<=M.
    always_comb begin
        mstatus_trap        = mstatus;
        mstatus_trap[7]     = mstatus[3];
        mstatus_trap[3]     = 1'b0;
        mstatus_trap[12:11] = 2'b11;
        mstatus_mret        = mstatus;
        mstatus_mret[3]     = mstatus[7];
        mstatus_mret[7]     = 1'b1;
        mstatus_mret[12:11] = 2'b11;
    end

    // CSR read mux, write-value computation and write enable
    always_comb begin
        rd_val = '0;
        rd_ok  = 1'b1;
        case (csr_addr_i)
            12'h300: rd_val = mstatus;
            12'h304: rd_val = mie;
            12'h305: rd_val = mtvec;
            12'h341: rd_val = mepc;
            12'h342: rd_val = mcause;
            12'h344: rd_val = mip;
`ifdef YSYX_22050598_CSR_MCYCLE_EN
            12'hB00: rd_val = mcycle;
`endif
            default: rd_ok = 1'b0;
        endcase
        case (op_i)
            OP_RS:   wval = rd_val | csr_src_i;
            OP_RC:   wval = rd_val & ~csr_src_i;
            default: wval = csr_src_i;
        endcase
        // RS/RC with a zero operand is a pure read
        wr_en = accept && !irq && is_csr && rd_ok
                && ((op_i == OP_RW) || (csr_src_i != '0));
    end

    // Handshake FSM, registered response and CSR state updates
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rsp_valid_o   <= 1'b0;
            rdata_o       <= '0;
            redirect_o    <= 1'b0;
            redirect_pc_o <= '0;
            illegal_o     <= 1'b0;
            irq_taken_o   <= 1'b0;
            mstatus       <= MSTATUS_RESETVAL;
            mtvec         <= {MTVEC_RESETVAL[XLEN-1:2], 2'b00};
            mie           <= '0;
            mepc          <= '0;
            mcause        <= '0;
        end else begin
            if (accept) begin
                state         <= RESP;
                rsp_valid_o   <= 1'b1;
                rdata_o       <= (is_csr && rd_ok && !irq) ? rd_val : '0;
                illegal_o     <= is_csr && !rd_ok && !irq;
                redirect_o    <= irq || ecall || mret;
                redirect_pc_o <= (irq || ecall) ? mtvec : (mret ? mepc : '0);
                irq_taken_o   <= irq;
            end else begin
                state         <= IDLE;
                rsp_valid_o   <= 1'b0;
                rdata_o       <= '0;
                illegal_o     <= 1'b0;
                redirect_o    <= 1'b0;
                redirect_pc_o <= '0;
                irq_taken_o   <= 1'b0;
            end
            if (wr_en) begin
                case (csr_addr_i)
                    12'h300: mstatus <= wval;
                    12'h304: mie     <= wval;
                    12'h305: mtvec   <= {wval[XLEN-1:2], 2'b00};
                    12'h341: mepc    <= {wval[XLEN-1:1], 1'b0};
                    12'h342: mcause  <= wval;
                    default: ;
                endcase
            end
            if (irq || ecall) begin
                mepc    <= pc_i;
                mstatus <= mstatus_trap;
                mcause  <= irq ? {1'b1, (XLEN-1)'(7)} : XLEN'(11);
            end
            if (mret) begin
                mstatus <= mstatus_mret;
            end
        end
    end

`ifdef YSYX_22050598_CSR_MCYCLE_EN
    // Free-running cycle counter; a CSR write takes precedence over the increment
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle <= '0;
        end else if (wr_en && (csr_addr_i == 12'hB00)) begin
            mcycle <= wval;
        end else begin
            mcycle <= mcycle + XLEN'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22050598_csr_file.sv
// Directed self-checking bench for ysyx_22050598_csr_file.
// Requests are driven on the falling edge and responses sampled on the following falling edge.
module tb_ysyx_22050598_csr_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  op_i;
    logic [11:0] csr_addr_i;
    logic [63:0] csr_src_i;
    logic [63:0] pc_i;
    logic        timer_irq_i;
    logic        rsp_valid_o;
    logic [63:0] rdata_o;
    logic        redirect_o;
    logic [63:0] redirect_pc_o;
    logic        illegal_o;
    logic        irq_taken_o;

    int checks = 0;
    int errors = 0;

    logic [63:0] r_rdata, r_rpc;
    logic        r_redir, r_ill, r_irq;

    ysyx_22050598_csr_file dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .op_i          (op_i),
        .csr_addr_i    (csr_addr_i),
        .csr_src_i     (csr_src_i),
        .pc_i          (pc_i),
        .timer_irq_i   (timer_irq_i),
        .rsp_valid_o   (rsp_valid_o),
        .rdata_o       (rdata_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .illegal_o     (illegal_o),
        .irq_taken_o   (irq_taken_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [2:0] op, input logic [11:0] addr,
                       input logic [63:0] src, input logic [63:0] pc);
        @(negedge clk);
        chk("ready_idle", 64'(req_ready_o), 64'd1);
        op_i        = op;
        csr_addr_i  = addr;
        csr_src_i   = src;
        pc_i        = pc;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        chk("rsp_valid", 64'(rsp_valid_o), 64'd1);
        chk("ready_resp", 64'(req_ready_o), 64'd0);
        r_rdata = rdata_o;
        r_rpc   = redirect_pc_o;
        r_redir = redirect_o;
        r_ill   = illegal_o;
        r_irq   = irq_taken_o;
    endtask

    initial begin
        rst         = 1'b1;
        req_valid_i = 1'b0;
        op_i        = 3'b000;
        csr_addr_i  = 12'h000;
        csr_src_i   = 64'd0;
        pc_i        = 64'd0;
        timer_irq_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_ready", 64'(req_ready_o), 64'd1);
        chk("rst_rdata", rdata_o, 64'd0);
        chk("rst_redirect", 64'(redirect_o), 64'd0);
        rst = 1'b0;

        // Reset values, RS with zero operand must not write
        req(3'b010, 12'h300, 64'd0, 64'd0);
        chk("mstatus_reset", r_rdata, 64'h1800);
        chk("rs0_illegal", 64'(r_ill), 64'd0);
        req(3'b010, 12'h300, 64'd0, 64'd0);
        chk("mstatus_nowrite", r_rdata, 64'h1800);
        req(3'b010, 12'h305, 64'd0, 64'd0);
        chk("mtvec_reset", r_rdata, 64'd0);

        // NOP ops
        req(3'b000, 12'h300, 64'hFF, 64'h1234);
        chk("nop0_rdata", r_rdata, 64'd0);
        chk("nop0_redir", 64'(r_redir), 64'd0);
        req(3'b110, 12'h300, 64'hFF, 64'h1234);
        chk("nop6_rdata", r_rdata, 64'd0);
        chk("nop6_ill", 64'(r_ill), 64'd0);

        // mtvec write with low bits masked, ECALL
        req(3'b001, 12'h305, 64'h8000_0003, 64'd0);
        chk("rw_mtvec_old", r_rdata, 64'd0);
        req(3'b010, 12'h305, 64'd0, 64'd0);
        chk("mtvec_masked", r_rdata, 64'h8000_0000);
        req(3'b100, 12'h000, 64'd0, 64'h8000_0100);
        chk("ecall_redir", 64'(r_redir), 64'd1);
        chk("ecall_rpc", r_rpc, 64'h8000_0000);
        chk("ecall_rdata", r_rdata, 64'd0);
        req(3'b010, 12'h341, 64'd0, 64'd0);
        chk("ecall_mepc", r_rdata, 64'h8000_0100);
        req(3'b010, 12'h342, 64'd0, 64'd0);
        chk("ecall_mcause", r_rdata, 64'd11);

        // MIE/MPIE stacking through ECALL and MRET
        req(3'b010, 12'h300, 64'd8, 64'd0);
        chk("rs_mstatus_old", r_rdata, 64'h1800);
        req(3'b100, 12'h000, 64'd0, 64'h8000_0200);
        chk("ecall2_rpc", r_rpc, 64'h8000_0000);
        req(3'b010, 12'h300, 64'd0, 64'd0);
        chk("ecall_stack", r_rdata, 64'h1880);
        req(3'b101, 12'h000, 64'd0, 64'd0);
        chk("mret_redir", 64'(r_redir), 64'd1);
        chk("mret_rpc", r_rpc, 64'h8000_0200);
        req(3'b010, 12'h300, 64'd0, 64'd0);
        chk("mret_unstack", r_rdata, 64'h1888);

        // Timer interrupt preempts a CSR write
        req(3'b010, 12'h304, 64'h80, 64'd0);
        chk("rs_mie_old", r_rdata, 64'd0);
        timer_irq_i = 1'b1;
        req(3'b001, 12'h341, 64'h1234, 64'h8000_0300);
        chk("irq_taken", 64'(r_irq), 64'd1);
        chk("irq_redir", 64'(r_redir), 64'd1);
        chk("irq_rpc", r_rpc, 64'h8000_0000);
        chk("irq_rdata", r_rdata, 64'd0);
        req(3'b010, 12'h342, 64'd0, 64'd0);
        chk("irq_mcause", r_rdata, 64'h8000_0000_0000_0007);
        req(3'b010, 12'h341, 64'd0, 64'd0);
        chk("irq_mepc", r_rdata, 64'h8000_0300);
        chk("irq_mepc_noirq", 64'(r_irq), 64'd0);
        req(3'b010, 12'h300, 64'd0, 64'd0);
        chk("irq_stack", r_rdata, 64'h1880);
        req(3'b010, 12'h344, 64'd0, 64'd0);
        chk("mip_pending", r_rdata, 64'h80);
        timer_irq_i = 1'b0;
        req(3'b011, 12'h304, 64'h80, 64'd0);
        chk("rc_mie_old", r_rdata, 64'h80);
        req(3'b010, 12'h304, 64'd0, 64'd0);
        chk("rc_mie_new", r_rdata, 64'd0);

        // Illegal address, read-only mip, mepc bit0 masking
        req(3'b001, 12'h7C0, 64'hDEAD, 64'd0);
        chk("illegal_flag", 64'(r_ill), 64'd1);
        chk("illegal_rdata", r_rdata, 64'd0);
        req(3'b001, 12'h344, 64'hFFFF, 64'd0);
        req(3'b010, 12'h344, 64'd0, 64'd0);
        chk("mip_ro", r_rdata, 64'd0);
        req(3'b001, 12'h341, 64'h8000_0401, 64'd0);
        req(3'b010, 12'h341, 64'd0, 64'd0);
        chk("mepc_masked", r_rdata, 64'h8000_0400);

`ifdef YSYX_22050598_CSR_MCYCLE_EN
        req(3'b001, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0);
        chk("mcycle_legal", 64'(r_ill), 64'd0);
        req(3'b010, 12'hB00, 64'd0, 64'd0);
        chk("mcycle_max", r_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        req(3'b010, 12'hB00, 64'd0, 64'd0);
        chk("mcycle_wrap", r_rdata, 64'd1);
`else
        req(3'b001, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0);
        chk("mcycle_absent", 64'(r_ill), 64'd1);
        chk("mcycle_rdata", r_rdata, 64'd0);
`endif

        // Reset while a response is in flight
        @(negedge clk);
        op_i        = 3'b010;
        csr_addr_i  = 12'h300;
        csr_src_i   = 64'd0;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        chk("inflight_valid", 64'(rsp_valid_o), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_drop_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_drop_ready", 64'(req_ready_o), 64'd1);
        chk("rst_drop_rdata", rdata_o, 64'd0);
        rst = 1'b0;
        req(3'b010, 12'h300, 64'd0, 64'd0);
        chk("rst_mstatus", r_rdata, 64'h1800);
        req(3'b010, 12'h305, 64'd0, 64'd0);
        chk("rst_mtvec", r_rdata, 64'd0);
        req(3'b010, 12'h341, 64'd0, 64'd0);
        chk("rst_mepc", r_rdata, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
